// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and default latencies for the pipeline hazard controller.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDone = 2'b10
  } mdu_state_e;

  localparam int unsigned MUL_LAT_DEF = 3;
  localparam int unsigned DIV_LAT_DEF = 34;
  localparam int unsigned CNT_W_DEF   = 6;

endpackage

// File: rtl/mdu_seq.sv
// MUL/DIV sequencer: holds the EX op for its full latency, then pulses done for one cycle.
module mdu_seq
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_div,
  output logic o_busy,
  output logic o_done,
  output logic o_freeze
);

  localparam logic [CNT_W-1:0] MulInit = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] DivInit = CNT_W'(DIV_LAT - 2);

  mdu_state_e       r_state;
  mdu_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_freeze    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          // The start cycle is occupancy cycle 1; a zero load means no BUSY cycles at all.
          w_cnt_nxt   = i_div ? DivInit : MulInit;
          w_state_nxt = (w_cnt_nxt == '0) ? StDone : StBusy;
          o_freeze    = 1'b1;
        end
      end
      StBusy: begin
        o_busy    = 1'b1;
        o_freeze  = 1'b1;
        w_cnt_nxt = r_cnt - 1'b1;
        if (w_cnt_nxt == '0) begin
          w_state_nxt = StDone;
        end
      end
      StDone: begin
        o_done      = 1'b1;
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: forwarding selects, load-use stall, redirect flush, MDU freeze.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush event counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] i_Rs1_D,
  input  logic [REG_AW-1:0] i_Rs2_D,
  input  logic [REG_AW-1:0] i_Rs1_E,
  input  logic [REG_AW-1:0] i_Rs2_E,
  input  logic [REG_AW-1:0] i_Rd_E,
  input  logic [REG_AW-1:0] i_Rd_M,
  input  logic [REG_AW-1:0] i_Rd_W,
  input  logic              i_regwrite_M,
  input  logic              i_regwrite_W,
  input  logic              i_memread_E,
  input  logic              i_redirect_E,
  input  logic              i_mdu_start_E,
  input  logic              i_mdu_div_E,
  output logic              o_stall_F,
  output logic              o_stall_D,
  output logic              o_flush_D,
  output logic              o_stall_E,
  output logic              o_flush_E,
  output logic              o_bubble_M,
  output logic [1:0]        o_fwd_a,
  output logic [1:0]        o_fwd_b,
  output logic              o_mdu_busy,
  output logic              o_mdu_done
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       o_stall_cnt,
  output logic [31:0]       o_flush_cnt
`endif
);

  logic w_busy;
  logic w_done;
  logic w_freeze;
  logic w_lu;

  mdu_seq #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_mdu_seq (
    .clk      (clk),
    .rst      (rst),
    .i_start  (i_mdu_start_E),
    .i_div    (i_mdu_div_E),
    .o_busy   (w_busy),
    .o_done   (w_done),
    .o_freeze (w_freeze)
  );

  // MEM is the younger producer, so it wins over WB; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic [REG_AW-1:0] rd_m,
                                         input logic              we_m,
                                         input logic [REG_AW-1:0] rd_w,
                                         input logic              we_w);
    if (we_m && (rd_m != '0) && (rd_m == rs)) begin
      return FWD_MEM;
    end else if (we_w && (rd_w != '0) && (rd_w == rs)) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

  assign w_lu = i_memread_E && (i_Rd_E != '0) && ((i_Rd_E == i_Rs1_D) || (i_Rd_E == i_Rs2_D));

  always_comb begin
    o_stall_F  = 1'b0;
    o_stall_D  = 1'b0;
    o_flush_D  = 1'b0;
    o_stall_E  = 1'b0;
    o_flush_E  = 1'b0;
    o_bubble_M = 1'b0;
    o_fwd_a    = FWD_RF;
    o_fwd_b    = FWD_RF;
    o_mdu_busy = 1'b0;
    o_mdu_done = 1'b0;
    if (!rst) begin
      o_fwd_a    = fwd_sel(i_Rs1_E, i_Rd_M, i_regwrite_M, i_Rd_W, i_regwrite_W);
      o_fwd_b    = fwd_sel(i_Rs2_E, i_Rd_M, i_regwrite_M, i_Rd_W, i_regwrite_W);
      o_mdu_busy = w_busy;
      o_mdu_done = w_done;
      if (w_freeze) begin
        o_stall_F  = 1'b1;
        o_stall_D  = 1'b1;
        o_stall_E  = 1'b1;
        o_bubble_M = 1'b1;
      end else if (i_redirect_E) begin
        o_flush_D = 1'b1;
        o_flush_E = 1'b1;
      end else if (w_lu) begin
        o_stall_F = 1'b1;
        o_stall_D = 1'b1;
        o_flush_E = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (o_stall_D && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (o_flush_D && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: combinational vector table plus MUL/DIV/reset sequences.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       we_m, we_w, memrd, redir, start, div;
  logic       stall_f, stall_d, flush_d, stall_e, flush_e, bubble_m;
  logic [1:0] fwd_a, fwd_b;
  logic       busy, done;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int n_total = 0;
  int n_pass  = 0;

  hazard_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .i_Rs1_D       (rs1_d),
    .i_Rs2_D       (rs2_d),
    .i_Rs1_E       (rs1_e),
    .i_Rs2_E       (rs2_e),
    .i_Rd_E        (rd_e),
    .i_Rd_M        (rd_m),
    .i_Rd_W        (rd_w),
    .i_regwrite_M  (we_m),
    .i_regwrite_W  (we_w),
    .i_memread_E   (memrd),
    .i_redirect_E  (redir),
    .i_mdu_start_E (start),
    .i_mdu_div_E   (div),
    .o_stall_F     (stall_f),
    .o_stall_D     (stall_d),
    .o_flush_D     (flush_d),
    .o_stall_E     (stall_e),
    .o_flush_E     (flush_e),
    .o_bubble_M    (bubble_m),
    .o_fwd_a       (fwd_a),
    .o_fwd_b       (fwd_b),
    .o_mdu_busy    (busy),
    .o_mdu_done    (done)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .o_stall_cnt   (stall_cnt),
    .o_flush_cnt   (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {stall_F, stall_D, flush_D, flush_E, stall_E, bubble_M}
  logic [5:0] ctl;
  assign ctl = {stall_f, stall_d, flush_d, flush_e, stall_e, bubble_m};

  localparam logic [5:0] CtlNone   = 6'b000000;
  localparam logic [5:0] CtlLu     = 6'b110100;
  localparam logic [5:0] CtlRedir  = 6'b001100;
  localparam logic [5:0] CtlFreeze = 6'b110011;

  typedef struct {
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       we_m, we_w, memrd, redir;
    logic [1:0] fa, fb;
    logic [5:0] ctl;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic idle_inputs();
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
    we_m = 1'b0; we_w = 1'b0; memrd = 1'b0; redir = 1'b0; start = 1'b0; div = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int busy_cycles;
  int done_cycle;
  int done_pulses;

  initial begin
    vecs[0]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, CtlNone};
    vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, CtlNone};
    vecs[2]  = '{5'd0, 5'd0, 5'd3, 5'd4, 5'd0, 5'd4, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b10, CtlNone};
    vecs[3]  = '{5'd0, 5'd0, 5'd6, 5'd6, 5'd0, 5'd6, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01, CtlNone};
    vecs[4]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, CtlNone};
    vecs[5]  = '{5'd1, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, CtlLu};
    vecs[6]  = '{5'd9, 5'd2, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, CtlLu};
    vecs[7]  = '{5'd0, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, CtlNone};
    vecs[8]  = '{5'd1, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, CtlNone};
    vecs[9]  = '{5'd1, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, CtlRedir};
    vecs[10] = '{5'd0, 5'd0, 5'd8, 5'd9, 5'd0, 5'd9, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 2'b10, CtlRedir};
    vecs[11] = '{5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, CtlNone};

    // Reset with hazards and a start request present: everything must read 0.
    idle_inputs();
    rst = 1'b1;
    rs1_e = 5'd5; rd_m = 5'd5; we_m = 1'b1;
    memrd = 1'b1; rd_e = 5'd7; rs2_d = 5'd7; redir = 1'b1; start = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("reset_outputs", {20'd0, ctl, fwd_a, fwd_b, busy, done}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    check("reset_stall_cnt", stall_cnt, 32'd0);
    check("reset_flush_cnt", flush_cnt, 32'd0);
`endif
    next_cycle();
    idle_inputs();
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      next_cycle();
      rs1_d = vecs[i].rs1_d; rs2_d = vecs[i].rs2_d; rs1_e = vecs[i].rs1_e;
      rs2_e = vecs[i].rs2_e; rd_e = vecs[i].rd_e; rd_m = vecs[i].rd_m; rd_w = vecs[i].rd_w;
      we_m = vecs[i].we_m; we_w = vecs[i].we_w; memrd = vecs[i].memrd; redir = vecs[i].redir;
      @(negedge clk);
      check($sformatf("vec%0d_fwd_a", i), {30'd0, fwd_a}, {30'd0, vecs[i].fa});
      check($sformatf("vec%0d_fwd_b", i), {30'd0, fwd_b}, {30'd0, vecs[i].fb});
      check($sformatf("vec%0d_ctl", i), {26'd0, ctl}, {26'd0, vecs[i].ctl});
    end

    // Load-use lasts one cycle, clears once the load has left EX.
    next_cycle();
    idle_inputs();
    memrd = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
    @(negedge clk);
    check("lu_cycle1", {26'd0, ctl}, {26'd0, CtlLu});
    next_cycle();
    memrd = 1'b0; rd_e = 5'd0;
    @(negedge clk);
    check("lu_cycle2", {26'd0, ctl}, {26'd0, CtlNone});

    // Multiply: start + 1 BUSY + DONE, then IDLE.
    next_cycle();
    idle_inputs();
    start = 1'b1; div = 1'b0;
    @(negedge clk);
    check("mul_c1_ctl", {26'd0, ctl}, {26'd0, CtlFreeze});
    check("mul_c1_busy_done", {30'd0, busy, done}, 32'd0);
    next_cycle();
    start = 1'b0;
    @(negedge clk);
    check("mul_c2_ctl", {26'd0, ctl}, {26'd0, CtlFreeze});
    check("mul_c2_busy_done", {30'd0, busy, done}, 32'd2);
    next_cycle();
    @(negedge clk);
    check("mul_c3_ctl", {26'd0, ctl}, {26'd0, CtlNone});
    check("mul_c3_busy_done", {30'd0, busy, done}, 32'd1);
    next_cycle();
    // A fresh load-use proves the FSM is back in IDLE.
    memrd = 1'b1; rd_e = 5'd4; rs1_d = 5'd4;
    @(negedge clk);
    check("mul_c4_busy_done", {30'd0, busy, done}, 32'd0);
    check("mul_c4_ctl", {26'd0, ctl}, {26'd0, CtlLu});

    // Divide: 32 BUSY cycles, done in cycle 34, redirect during BUSY is ignored.
    next_cycle();
    idle_inputs();
    start = 1'b1; div = 1'b1;
    busy_cycles = 0; done_cycle = 0; done_pulses = 0;
    for (int cyc = 1; cyc <= 38; cyc++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        done_pulses++;
        done_cycle = cyc;
      end
      if (cyc == 10) begin
        check("div_redirect_no_flush", {26'd0, ctl}, {26'd0, CtlFreeze});
      end
      if (cyc == 33) begin
        check("div_c33_ctl", {26'd0, ctl}, {26'd0, CtlFreeze});
      end
      next_cycle();
      start = 1'b0;
      redir = (cyc + 1 == 10);
    end
    check("div_busy_cycles", busy_cycles, 32'd32);
    check("div_done_cycle", done_cycle, 32'd34);
    check("div_done_pulses", done_pulses, 32'd1);

    // Reset asserted at cycle 10 of a divide: aborted, no done pulse afterwards.
    idle_inputs();
    start = 1'b1; div = 1'b1;
    for (int cyc = 1; cyc < 10; cyc++) begin
      @(negedge clk);
      next_cycle();
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_in_reset", {20'd0, ctl, fwd_a, fwd_b, busy, done}, 32'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("abort_after_reset", {20'd0, ctl, fwd_a, fwd_b, busy, done}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    check("abort_stall_cnt", stall_cnt, 32'd0);
    check("abort_flush_cnt", flush_cnt, 32'd0);
`endif
    done_pulses = 0;
    busy_cycles = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      next_cycle();
      @(negedge clk);
      if (done) done_pulses++;
      if (busy) busy_cycles++;
    end
    check("abort_no_done", done_pulses, 32'd0);
    check("abort_no_busy", busy_cycles, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
